// File: rtl/ddma_engine.sv
// ddma_engine: single-channel memory-to-NoC DMA engine.
// A rising edge on cmd_in reads ceil(nbytes/B) words from local memory,
// starting at addr_in. Each word is split into R flits, sent least-significant first.
module ddma_engine #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int FLIT_WIDTH       = 16,
    parameter int ADDRESS          = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [MEMORY_BUS_WIDTH-3:0]   addr_in,
    input  logic [MEMORY_BUS_WIDTH-3:0]   nbytes_in,
    input  logic                          cmd_in,
    output logic [4:0]                    status_out,
    output logic [4:0]                    irq_out,
    output logic [MEMORY_BUS_WIDTH-3:0]   mem_addr_out,
    output logic                          mem_rd_out,
    input  logic [MEMORY_BUS_WIDTH-1:0]   mem_data_in,
    output logic [FLIT_WIDTH-1:0]         flit_out,
    output logic                          flit_valid_out,
    input  logic                          flit_ready_in
);

    localparam int AW   = MEMORY_BUS_WIDTH - 2;
    localparam int R    = MEMORY_BUS_WIDTH / FLIT_WIDTH;
    localparam int B    = MEMORY_BUS_WIDTH / 8;
    localparam int IDXW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic                      cmd_q;
    logic [AW-1:0]             addr_q;
    logic [AW:0]               words_q;
    logic [MEMORY_BUS_WIDTH-1:0] buf_q;
    logic [IDXW-1:0]           idx_q;
    logic                      done_q, zero_q, ovr_q;
    logic                      start;
    logic                      stall;
    logic [AW:0]               words_calc;
    logic [FLIT_WIDTH-1:0]     flit_sel;

    assign start = cmd_in & ~cmd_q;

    // Word count, computed one bit wider than nbytes so the round-up add cannot overflow
    always_comb begin
        words_calc = ({1'b0, nbytes_in} + (AW+1)'(B - 1)) / (AW+1)'(B);
    end

    // Select the current flit out of the buffered word
    always_comb begin
        flit_sel = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (idx_q == IDXW'(i)) begin
                flit_sel = buf_q[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state outputs
    always_comb begin
        state_d        = state_q;
        mem_rd_out     = 1'b0;
        mem_addr_out   = '0;
        flit_valid_out = 1'b0;
        flit_out       = '0;
        irq_out        = '0;
        stall          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (words_calc == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                mem_rd_out   = 1'b1;
                mem_addr_out = addr_q;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                flit_valid_out = 1'b1;
                flit_out       = flit_sel;
                stall          = ~flit_ready_in;
                if (flit_ready_in && (idx_q == IDXW'(R - 1))) begin
                    state_d = (words_q != '0) ? S_RD : S_DONE;
                end
            end
            S_DONE: begin
                irq_out[ADDRESS] = 1'b1;
                state_d          = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: command edge detect, address/word counters, word buffer, sticky status
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q   <= 1'b1;
            addr_q  <= '0;
            words_q <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cmd_q <= cmd_in;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= addr_in;
                        words_q <= words_calc;
                        done_q  <= 1'b0;
                        zero_q  <= (words_calc == '0);
                        ovr_q   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    buf_q   <= mem_data_in;
                    addr_q  <= addr_q + 1'b1;
                    words_q <= words_q - 1'b1;
                    idx_q   <= '0;
                end
                S_SEND: begin
                    if (flit_ready_in) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                end
            endcase
            if (start && (state_q != S_IDLE)) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign status_out = {stall, ovr_q, zero_q, done_q, (state_q != S_IDLE)};

endmodule

// File: tb/tb_ddma_engine.sv
// Directed testbench for ddma_engine (32-bit memory, 16-bit flits, channel 0).
module tb_ddma_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic [29:0] addr_in;
    logic [29:0] nbytes_in;
    logic        cmd_in;
    logic [4:0]  status_out;
    logic [4:0]  irq_out;
    logic [29:0] mem_addr_out;
    logic        mem_rd_out;
    logic [31:0] mem_data_in = '0;
    logic [15:0] flit_out;
    logic        flit_valid_out;
    logic        flit_ready_in;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [29:0] rd_q[$];
    int          rd_cyc_q[$];
    logic [15:0] fl_q[$];
    int          fl_cyc_q[$];
    int          irq_n   = 0;
    int          irq_cyc = -1;
    logic [4:0]  irq_val = '0;

    ddma_engine #(
        .MEMORY_BUS_WIDTH(32),
        .FLIT_WIDTH(16),
        .ADDRESS(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .addr_in(addr_in),
        .nbytes_in(nbytes_in),
        .cmd_in(cmd_in),
        .status_out(status_out),
        .irq_out(irq_out),
        .mem_addr_out(mem_addr_out),
        .mem_rd_out(mem_rd_out),
        .mem_data_in(mem_data_in),
        .flit_out(flit_out),
        .flit_valid_out(flit_valid_out),
        .flit_ready_in(flit_ready_in)
    );

    always #5 clock = ~clock;

    // Cycle counter: holds k during the cycle following edge k
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        case (a)
            30'h10:       return 32'hAAAA5555;
            30'h11:       return 32'h12345678;
            30'h20:       return 32'h11112222;
            30'h21:       return 32'h33334444;
            30'h3FFFFFFF: return 32'hCAFEF00D;
            30'h0:        return 32'h0BADBEEF;
            default:      return 32'hDEADBEEF;
        endcase
    endfunction

    // Memory returns data in the cycle after the read strobe
    always @(posedge clock) if (mem_rd_out) mem_data_in <= mem_word(mem_addr_out);

    // Monitor: record reads, accepted flits and irq pulses mid-cycle
    always @(negedge clock) begin
        if (mem_rd_out) begin
            rd_q.push_back(mem_addr_out);
            rd_cyc_q.push_back(cyc);
        end
        if (flit_valid_out && flit_ready_in) begin
            fl_q.push_back(flit_out);
            fl_cyc_q.push_back(cyc);
        end
        if (irq_out != 5'b0) begin
            irq_n   = irq_n + 1;
            irq_cyc = cyc;
            irq_val = irq_out;
        end
    end

    task automatic clear_mon();
        rd_q.delete();
        rd_cyc_q.delete();
        fl_q.delete();
        fl_cyc_q.delete();
        irq_n   = 0;
        irq_cyc = -1;
        irq_val = '0;
    endtask

    task automatic start_xfer(input logic [29:0] a, input logic [29:0] n, output int k);
        @(posedge clock); #1;
        addr_in   = a;
        nbytes_in = n;
        cmd_in    = 1'b1;
        @(posedge clock); #1;
        k      = cyc;
        cmd_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (status_out[0] && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (status_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout busy=%b required=0 after %0d cycles", name, status_out[0], budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_in = 1'b1; flit_ready_in = 1'b1; addr_in = '0; nbytes_in = 30'd8;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({status_out, irq_out, mem_rd_out, mem_addr_out, flit_valid_out, flit_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs status=%b irq=%b rd=%b addr=%h valid=%b flit=%h required all 0",
                     status_out, irq_out, mem_rd_out, mem_addr_out, flit_valid_out, flit_out);
        end
        clear_mon();
        repeat (10) @(posedge clock);
        #1;
        checks++;
        if (status_out !== 5'b0 || irq_out !== 5'b0) begin
            failures++;
            $display("FAIL reset_cmd_high status=%b irq=%b required 00000/00000", status_out, irq_out);
        end
        checks++;
        if (rd_q.size() != 0 || fl_q.size() != 0 || irq_n != 0) begin
            failures++;
            $display("FAIL reset_no_xfer reads=%0d flits=%0d irqs=%0d required 0/0/0", rd_q.size(), fl_q.size(), irq_n);
        end
        cmd_in = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int k;
        logic [15:0] exp_f[4] = '{16'h5555, 16'hAAAA, 16'h5678, 16'h1234};
        clear_mon();
        start_xfer(30'h10, 30'd8, k);
        checks++;
        if (mem_rd_out !== 1'b1 || mem_addr_out !== 30'h10) begin
            failures++;
            $display("FAIL basic_rd_at_k rd=%b addr=%h required 1/10", mem_rd_out, mem_addr_out);
        end
        wait_idle(40, "basic");
        checks++;
        if (rd_q.size() != 2) begin
            failures++;
            $display("FAIL basic_read_count got=%0d required=2", rd_q.size());
        end else begin
            checks++;
            if (rd_q[0] !== 30'h10 || rd_q[1] !== 30'h11 || rd_cyc_q[0] != k || rd_cyc_q[1] != k + 4) begin
                failures++;
                $display("FAIL basic_reads got=%h@%0d,%h@%0d required 10@%0d,11@%0d",
                         rd_q[0], rd_cyc_q[0], rd_q[1], rd_cyc_q[1], k, k + 4);
            end
        end
        checks++;
        if (fl_q.size() != 4) begin
            failures++;
            $display("FAIL basic_flit_count got=%0d required=4", fl_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (fl_q[i] !== exp_f[i]) begin
                    failures++;
                    $display("FAIL basic_flit%0d got=%h required=%h", i, fl_q[i], exp_f[i]);
                end
            end
            checks++;
            if (fl_cyc_q[0] != k + 2) begin
                failures++;
                $display("FAIL basic_first_flit_cycle got=%0d required=%0d", fl_cyc_q[0], k + 2);
            end
        end
        checks++;
        if (irq_n != 1 || irq_cyc != k + 8 || irq_val !== 5'b00001) begin
            failures++;
            $display("FAIL basic_irq count=%0d cycle=%0d val=%b required 1/%0d/00001", irq_n, irq_cyc, irq_val, k + 8);
        end
        checks++;
        if (status_out !== 5'b00010) begin
            failures++;
            $display("FAIL basic_status got=%b required=00010", status_out);
        end
    endtask

    task automatic test_partial();
        int k;
        logic [15:0] exp_f[4] = '{16'h2222, 16'h1111, 16'h4444, 16'h3333};
        clear_mon();
        start_xfer(30'h20, 30'd5, k);
        wait_idle(40, "partial");
        checks++;
        if (rd_q.size() != 2 || fl_q.size() != 4) begin
            failures++;
            $display("FAIL partial_counts reads=%0d flits=%0d required 2/4", rd_q.size(), fl_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (fl_q[i] !== exp_f[i]) begin
                    failures++;
                    $display("FAIL partial_flit%0d got=%h required=%h", i, fl_q[i], exp_f[i]);
                end
            end
        end
        checks++;
        if (irq_n != 1 || irq_cyc != k + 8) begin
            failures++;
            $display("FAIL partial_irq count=%0d cycle=%0d required 1/%0d", irq_n, irq_cyc, k + 8);
        end
    endtask

    task automatic test_zero_length();
        int k;
        clear_mon();
        start_xfer(30'h10, 30'd0, k);
        wait_idle(10, "zero");
        checks++;
        if (rd_q.size() != 0 || fl_q.size() != 0) begin
            failures++;
            $display("FAIL zero_no_reads reads=%0d flits=%0d required 0/0", rd_q.size(), fl_q.size());
        end
        checks++;
        if (irq_n != 1 || irq_cyc != k || irq_val !== 5'b00001) begin
            failures++;
            $display("FAIL zero_irq count=%0d cycle=%0d val=%b required 1/%0d/00001", irq_n, irq_cyc, irq_val, k);
        end
        checks++;
        if (status_out !== 5'b00110) begin
            failures++;
            $display("FAIL zero_status got=%b required=00110", status_out);
        end
    endtask

    task automatic test_stall();
        int k;
        logic [15:0] exp_f[4] = '{16'h5555, 16'hAAAA, 16'h5678, 16'h1234};
        clear_mon();
        start_xfer(30'h10, 30'd8, k);
        repeat (3) @(posedge clock);
        #1 flit_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (flit_valid_out !== 1'b1 || flit_out !== 16'hAAAA || status_out[4] !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d valid=%b flit=%h stall=%b required 1/aaaa/1",
                         i, flit_valid_out, flit_out, status_out[4]);
            end
            @(posedge clock); #1;
        end
        flit_ready_in = 1'b1;
        wait_idle(40, "stall");
        checks++;
        if (fl_q.size() != 4) begin
            failures++;
            $display("FAIL stall_flit_count got=%0d required=4", fl_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (fl_q[i] !== exp_f[i]) begin
                    failures++;
                    $display("FAIL stall_flit%0d got=%h required=%h", i, fl_q[i], exp_f[i]);
                end
            end
        end
        checks++;
        if (irq_n != 1 || irq_cyc != k + 11) begin
            failures++;
            $display("FAIL stall_irq count=%0d cycle=%0d required 1/%0d", irq_n, irq_cyc, k + 11);
        end
        checks++;
        if (status_out !== 5'b00010) begin
            failures++;
            $display("FAIL stall_status got=%b required=00010", status_out);
        end
    endtask

    task automatic test_overrun();
        int k;
        logic [15:0] exp_f[4] = '{16'h5555, 16'hAAAA, 16'h5678, 16'h1234};
        clear_mon();
        start_xfer(30'h10, 30'd8, k);
        @(posedge clock); #1;
        addr_in   = 30'h20;
        nbytes_in = 30'd0;
        cmd_in    = 1'b1;
        @(posedge clock); #1;
        cmd_in = 1'b0;
        #1;
        checks++;
        if (status_out !== 5'b01001) begin
            failures++;
            $display("FAIL overrun_flag got=%b required=01001", status_out);
        end
        wait_idle(40, "overrun");
        checks++;
        if (rd_q.size() != 2 || fl_q.size() != 4) begin
            failures++;
            $display("FAIL overrun_counts reads=%0d flits=%0d required 2/4", rd_q.size(), fl_q.size());
        end else begin
            checks++;
            if (rd_q[0] !== 30'h10 || rd_q[1] !== 30'h11) begin
                failures++;
                $display("FAIL overrun_reads got=%h,%h required 10,11", rd_q[0], rd_q[1]);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (fl_q[i] !== exp_f[i]) begin
                    failures++;
                    $display("FAIL overrun_flit%0d got=%h required=%h", i, fl_q[i], exp_f[i]);
                end
            end
        end
        checks++;
        if (irq_n != 1 || irq_cyc != k + 8 || status_out !== 5'b01010) begin
            failures++;
            $display("FAIL overrun_end irqs=%0d cycle=%0d status=%b required 1/%0d/01010", irq_n, irq_cyc, status_out, k + 8);
        end
    endtask

    task automatic test_wrap();
        int k;
        logic [15:0] exp_f[4] = '{16'hF00D, 16'hCAFE, 16'hBEEF, 16'h0BAD};
        clear_mon();
        start_xfer(30'h3FFFFFFF, 30'd8, k);
        wait_idle(40, "wrap");
        checks++;
        if (rd_q.size() != 2) begin
            failures++;
            $display("FAIL wrap_read_count got=%0d required=2", rd_q.size());
        end else begin
            checks++;
            if (rd_q[0] !== 30'h3FFFFFFF || rd_q[1] !== 30'h0) begin
                failures++;
                $display("FAIL wrap_reads got=%h,%h required 3fffffff,00000000", rd_q[0], rd_q[1]);
            end
        end
        checks++;
        if (fl_q.size() != 4) begin
            failures++;
            $display("FAIL wrap_flit_count got=%0d required=4", fl_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (fl_q[i] !== exp_f[i]) begin
                    failures++;
                    $display("FAIL wrap_flit%0d got=%h required=%h", i, fl_q[i], exp_f[i]);
                end
            end
        end
        checks++;
        if (status_out !== 5'b00010) begin
            failures++;
            $display("FAIL wrap_status got=%b required=00010", status_out);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        logic [15:0] exp_f[4] = '{16'h2222, 16'h1111, 16'h4444, 16'h3333};
        clear_mon();
        start_xfer(30'h10, 30'd8, k);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (flit_valid_out !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_in_send valid=%b required=1", flit_valid_out);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({status_out, irq_out, mem_rd_out, mem_addr_out, flit_valid_out, flit_out} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs status=%b irq=%b rd=%b addr=%h valid=%b flit=%h required all 0",
                     status_out, irq_out, mem_rd_out, mem_addr_out, flit_valid_out, flit_out);
        end
        repeat (6) @(posedge clock);
        #1;
        checks++;
        if (irq_n != 0 || fl_q.size() != 1 || rd_q.size() != 1 || status_out !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_dropped irqs=%0d flits=%0d reads=%0d status=%b required 0/1/1/00000",
                     irq_n, fl_q.size(), rd_q.size(), status_out);
        end
        clear_mon();
        start_xfer(30'h20, 30'd8, k);
        wait_idle(40, "rstmid_restart");
        checks++;
        if (fl_q.size() != 4) begin
            failures++;
            $display("FAIL rstmid_flit_count got=%0d required=4", fl_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (fl_q[i] !== exp_f[i]) begin
                    failures++;
                    $display("FAIL rstmid_flit%0d got=%h required=%h", i, fl_q[i], exp_f[i]);
                end
            end
        end
        checks++;
        if (irq_n != 1 || irq_cyc != k + 8 || status_out !== 5'b00010) begin
            failures++;
            $display("FAIL rstmid_restart irqs=%0d cycle=%0d status=%b required 1/%0d/00010", irq_n, irq_cyc, status_out, k + 8);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_zero_length();
        test_stall();
        test_overrun();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddma_engine.md
# ddma_engine

Memory-to-NoC DMA engine for one channel, the consumer of the TCD command interface. On a rising edge of `cmd_in`, it reads `ceil(nbytes_in / (MEMORY_BUS_WIDTH/8))` words from local memory, starting at word address `addr_in`. Each word is split into `MEMORY_BUS_WIDTH/FLIT_WIDTH` flits and streamed to the router's local input port. The engine reports progress on `status_out` and pulses its channel bit on `irq_out`.

## Interface
- `MEMORY_BUS_WIDTH`, default 32: memory data width. It must be an integer multiple of `FLIT_WIDTH`.
- `FLIT_WIDTH`, default 16: NoC flit width.
- `ADDRESS`, default 0: channel index, 0..4. Selects which `irq_out` bit this engine drives.
- `clock` in 1: the single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `addr_in` in MEMORY_BUS_WIDTH-2: start word address. Sampled on the start edge.
- `nbytes_in` in MEMORY_BUS_WIDTH-2: transfer length in bytes. Sampled on the start edge.
- `cmd_in` in 1: command. A 0→1 transition starts a transfer.
- `status_out` out 5: bit 0 busy, bit 1 done, bit 2 zero-length, bit 3 overrun, bit 4 stall.
- `irq_out` out 5: completion pulse, on bit `ADDRESS` only. All other bits are constant 0.
- `mem_addr_out` out MEMORY_BUS_WIDTH-2: memory word address.
- `mem_rd_out` out 1: memory read strobe.
- `mem_data_in` in MEMORY_BUS_WIDTH: read data, valid in the cycle after `mem_rd_out`.
- `flit_out` out FLIT_WIDTH: flit to the router.
- `flit_valid_out` out 1: flit valid.
- `flit_ready_in` in 1: router accepts the flit this cycle.

## Operation
- Constants: R = MEMORY_BUS_WIDTH/FLIT_WIDTH (flits per word); B = MEMORY_BUS_WIDTH/8 (bytes per word).
- Start edge: `cmd_in`=1 and `cmd_q`=0, where `cmd_q` is `cmd_in` registered every cycle.
  - `cmd_q` resets to 1, so a `cmd_in` held high through reset does not start a transfer.
- States: IDLE, RD, WAIT, SEND, DONE.
- IDLE, start edge seen:
  - Latch `addr_in` into the address counter.
  - Latch W = (`nbytes_in` + B − 1) / B. Compute in MEMORY_BUS_WIDTH-1 bits so the addition cannot overflow.
  - Clear `status_out` bits 1–3.
  - If W = 0: set bit 2 and go to DONE. Otherwise go to RD.
- RD: drive `mem_rd_out`=1 and `mem_addr_out`=address counter. Next state is WAIT.
- WAIT: capture `mem_data_in` into the word buffer on the closing edge. Increment the address, wrapping modulo 2^(MEMORY_BUS_WIDTH-2). Decrement W. Next state is SEND with flit index 0.
- SEND: drive `flit_valid_out`=1 and `flit_out` = buffer[(idx+1)·FLIT_WIDTH−1 : idx·FLIT_WIDTH]. Flits go out least-significant first.
  - On valid && ready: increment idx.
  - After flit R−1 is accepted: go to RD if W > 0, else DONE.
  - If ready=0: hold `flit_out`, keep `flit_valid_out` high, and set `status_out[4]` combinationally for that cycle.
- DONE: `irq_out[ADDRESS]`=1 for exactly one cycle. Set `status_out[1]` (sticky until the next accepted start). Next state is IDLE.
- `status_out[0]` = 1 in every state except IDLE.
- A start edge in any non-IDLE state is ignored and sets `status_out[3]` (sticky until the next accepted start).
- A partial last word still emits all R flits. The bytes beyond `nbytes_in` are whatever memory returned.
- `mem_addr_out` = 0 whenever `mem_rd_out` = 0. `flit_out` = 0 whenever `flit_valid_out` = 0.

## Timing
- Reset, taking effect at the next edge, even mid-transfer:
  - State returns to IDLE, W = 0, `cmd_q` = 1.
  - All outputs are 0: `status_out`, `irq_out`, `mem_rd_out`, `mem_addr_out`, `flit_valid_out`, `flit_out`.
  - In-flight flits are dropped. No irq is raised.
- Start edge sampled at edge k:
  - RD in cycle k.
  - WAIT in cycle k+1.
  - First `flit_valid_out` in cycle k+2.
- Per word, with no stalls: 2+R cycles. DONE falls in cycle k + W·(2+R).
- Each stalled cycle adds exactly one cycle to the transfer.
- Zero length: DONE in cycle k. The irq pulse occurs in cycle k, and no memory read is issued.
- The earliest next accepted start edge is 2 cycles after DONE, because `cmd_in` must fall and rise again.

## Test plan
- Reset release with `cmd_in`=1 held, then run 10 cycles -> no transfer; `status_out`=0, `irq_out`=0.
- R=2, `addr_in`=0x10, `nbytes_in`=8, memory[0x10]=0xAAAA5555, memory[0x11]=0x12345678, ready always 1. Required response:
  - Reads at 0x10 and 0x11.
  - Flits 0x5555, 0xAAAA, 0x5678, 0x1234.
  - `irq_out`=5'b00001 for one cycle at k+8.
  - `status_out` ends 5'b00010.
- `nbytes_in`=5 -> W=2; the 4 flits are still sent. `nbytes_in`=0 -> no reads; irq at cycle k; `status_out`=5'b00110.
- Drop `flit_ready_in` for 3 cycles on the second flit -> flit held stable, `status_out[4]`=1 during those cycles, DONE 3 cycles later.
- Second `cmd_in` edge while busy -> ignored, `status_out[3]`=1, the current transfer completes unchanged. `addr_in`=all ones with W=2 -> second read at address 0.
- Reset asserted in SEND -> next cycle IDLE, all outputs 0, no irq. A new start edge then transfers normally.
